nlf_enum_ctrl: RTL and testbench

//  Sequencer for the Crypto1 4-input NLF preimage enumerator in the state-recovery datapath.

---
 rtl/crypto1_pkg.sv | 23 ++
 rtl/nlf_preimage_lut.sv | 14 +
 rtl/nlf_enum_ctrl.sv | 103 ++++++++++
 tb/tb_nlf_enum_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/crypto1_pkg.sv
// rtl/crypto1_pkg.sv - Crypto1 NLF constants, preimage lookup function and enumerator state type
package crypto1_pkg;

   localparam logic [15:0] NLF_FN = 16'h9E98;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} nlf_enum_st_e;

   // k-th ascending nibble n with fn[n] == b; only meaningful when fn has exactly 8 ones
   function automatic logic [3:0] nlf_pre(input logic [15:0] fn, input logic b, input logic [2:0] k);
      logic [3:0] res;
      int         cnt;
      res = 4'd0;
      cnt = 0;
      for (int n = 0; n < 16; n++) begin
         if (fn[n] == b) begin
            if (cnt == int'(k)) res = 4'(n);
            cnt++;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/nlf_preimage_lut.sv
// rtl/nlf_preimage_lut.sv - maps (target bit, preimage index) to a filter nibble
module nlf_preimage_lut
   import crypto1_pkg::*;
#(
   parameter logic [15:0] FN = NLF_FN
) (
   input  logic       BIT,
   input  logic [2:0] IDX,
   output logic [3:0] NIB
);

   assign NIB = nlf_pre(FN, BIT, IDX);

endmodule

// File: rtl/nlf_enum_ctrl.sv
// rtl/nlf_enum_ctrl.sv - sequencer streaming every NLF preimage word for a target bit vector
module nlf_enum_ctrl
   import crypto1_pkg::*;
#(
   parameter int          NNIB = 5,
   parameter logic [15:0] FN   = NLF_FN
) (
   input  logic                CLK,
   input  logic                RESETn,
   input  logic                START,
   input  logic [NNIB-1:0]     TARGET,
   input  logic                ABORT,
   output logic                BUSY,
   output logic                CAND_VALID,
   input  logic                CAND_READY,
   output logic [4*NNIB-1:0]   CAND,
   output logic                CAND_LAST,
   output logic                DONE,
   output logic [3*NNIB:0]     COUNT
);

   localparam int          IW       = 3 * NNIB;
   localparam logic [IW:0] RUN_SIZE = {1'b1, {IW{1'b0}}};

   if ($countones(FN) != 8) begin : g_fn_check
      $error("nlf_enum_ctrl: FN must have exactly 8 ones");
   end

   nlf_enum_st_e      st;
   logic [NNIB-1:0]   target_q;
   logic [IW-1:0]     idx;
   logic [4*NNIB-1:0] cand_map;
   logic              xfer;
   logic              load;
   logic              idx_last;

   assign xfer     = CAND_VALID & CAND_READY;
   assign load     = !CAND_VALID | CAND_READY;
   assign idx_last = &idx;
   assign BUSY     = (st != IDLE);

   for (genvar i = 0; i < NNIB; i++) begin : g_lut
      nlf_preimage_lut #(.FN(FN)) u_lut (
         .BIT (target_q[i]),
         .IDX (idx[3*i +: 3]),
         .NIB (cand_map[4*i +: 4])
      );
   end

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         st         <= IDLE;
         target_q   <= '0;
         idx        <= '0;
         CAND       <= '0;
         CAND_VALID <= 1'b0;
         CAND_LAST  <= 1'b0;
         DONE       <= 1'b0;
         COUNT      <= '0;
      end else begin
         DONE <= 1'b0;
         // a transfer in an ABORT cycle still counts, so this sits outside the state case
         if (xfer && COUNT != RUN_SIZE) COUNT <= COUNT + {{IW{1'b0}}, 1'b1};
         case (st)
            IDLE: begin
               if (START && !ABORT) begin
                  target_q <= TARGET;
                  idx      <= '0;
                  COUNT    <= '0;
                  st       <= RUN;
               end
            end
            RUN: begin
               if (ABORT) begin
                  CAND_VALID <= 1'b0;
                  CAND_LAST  <= 1'b0;
                  st         <= IDLE;
               end else if (load) begin
                  CAND       <= cand_map;
                  CAND_VALID <= 1'b1;
                  CAND_LAST  <= idx_last;
                  if (idx_last) st <= DRAIN;
                  else          idx <= idx + {{(IW-1){1'b0}}, 1'b1};
               end
            end
            DRAIN: begin
               if (ABORT) begin
                  CAND_VALID <= 1'b0;
                  CAND_LAST  <= 1'b0;
                  st         <= IDLE;
               end else if (xfer) begin
                  CAND_VALID <= 1'b0;
                  CAND_LAST  <= 1'b0;
                  DONE       <= 1'b1;
                  st         <= IDLE;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nlf_enum_ctrl.sv
// tb/tb_nlf_enum_ctrl.sv - self-checking bench for nlf_enum_ctrl
module tb_nlf_enum_ctrl;

   logic       CLK = 1'b0;
   logic       RESETn, START, ABORT, CAND_READY;
   logic [1:0] TARGET;
   logic       BUSY, CAND_VALID, CAND_LAST, DONE;
   logic [7:0] CAND;
   logic [6:0] COUNT;

   logic        START5, ABORT5, READY5;
   logic [4:0]  TARGET5;
   logic        BUSY5, VALID5, LAST5, DONE5;
   logic [19:0] CAND5;
   logic [15:0] COUNT5;

   always #5 CLK = ~CLK;

   nlf_enum_ctrl #(.NNIB(2), .FN(16'h9E98)) dut (
      .CLK(CLK), .RESETn(RESETn), .START(START), .TARGET(TARGET), .ABORT(ABORT),
      .BUSY(BUSY), .CAND_VALID(CAND_VALID), .CAND_READY(CAND_READY), .CAND(CAND),
      .CAND_LAST(CAND_LAST), .DONE(DONE), .COUNT(COUNT)
   );

   nlf_enum_ctrl #(.NNIB(5)) dut5 (
      .CLK(CLK), .RESETn(RESETn), .START(START5), .TARGET(TARGET5), .ABORT(ABORT5),
      .BUSY(BUSY5), .CAND_VALID(VALID5), .CAND_READY(READY5), .CAND(CAND5),
      .CAND_LAST(LAST5), .DONE(DONE5), .COUNT(COUNT5)
   );

   typedef struct {
      logic [1:0] tgt;
      bit         rnd;
      int         mode;      // 0 full run, 1 abort at stop_at, 2 reset after stop_at
      int         stop_at;
      bit         glitch;
      logic [7:0] first;
      logic [7:0] last;
      int         count;
   } vec_t;

   vec_t        vecs[8];
   logic [3:0]  zero_t[8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd8, 4'd13, 4'd14};
   logic [3:0]  one_t[8]  = '{4'd3, 4'd4, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd15};
   logic [15:0] fn_c      = 16'h9E98;
   logic [7:0]  q[$];
   bit          seen[256];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [1:0] t, input int k);
      logic [3:0] lo, hi;
      lo = t[0] ? one_t[k % 8] : zero_t[k % 8];
      hi = t[1] ? one_t[k / 8] : zero_t[k / 8];
      return {hi, lo};
   endfunction

   task automatic run_vec(input vec_t v);
      logic [7:0] held, exp_c, last_c;
      bit         stalled, stop;
      int         nx;
      q.delete();
      seen = '{default: 1'b0};
      for (int k = 0; k < 64; k++) q.push_back(model(v.tgt, k));
      TARGET = v.tgt; START = 1'b1; CAND_READY = 1'b0;
      @(negedge CLK); START = 1'b0;
      check("t1_valid", CAND_VALID, 0);
      check("t1_busy", BUSY, 1);
      @(negedge CLK);
      check("t2_valid", CAND_VALID, 1);
      check("first_cand", CAND, v.first);
      stalled = 0; stop = 0; nx = 0; held = '0; last_c = '0;
      for (int cyc = 0; cyc < 2000 && !stop && q.size() > 0; cyc++) begin
         if (cyc > 0) @(negedge CLK);
         START = v.glitch && nx == 5;
         if (stalled) begin
            check("stall_cand", CAND, held);
            check("stall_valid", CAND_VALID, 1);
         end
         CAND_READY = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (CAND_VALID && CAND_READY) begin
            exp_c = q.pop_front();
            check("cand", CAND, exp_c);
            check("cand_last", CAND_LAST, q.size() == 0);
            check("fn_match", {fn_c[CAND[7:4]], fn_c[CAND[3:0]]}, v.tgt);
            check("unique", seen[CAND], 0);
            seen[CAND] = 1'b1;
            last_c = CAND;
            nx++;
            stalled = 0;
            if (v.mode == 1 && nx == v.stop_at) begin ABORT = 1'b1; stop = 1; end
            if (v.mode == 2 && nx == v.stop_at) stop = 1;
         end else begin
            stalled = CAND_VALID;
            held = CAND;
         end
      end
      @(negedge CLK);
      START = 1'b0; ABORT = 1'b0;
      case (v.mode)
         0: begin
            check("drained", q.size(), 0);
            check("done_pulse", DONE, 1);
            check("end_valid", CAND_VALID, 0);
            check("end_busy", BUSY, 0);
            check("last_val", last_c, v.last);
            @(negedge CLK);
            check("done_one_cycle", DONE, 0);
         end
         1: begin
            check("abort_valid", CAND_VALID, 0);
            check("abort_last", CAND_LAST, 0);
            check("abort_busy", BUSY, 0);
            for (int i = 0; i < 3; i++) begin
               check("abort_no_done", DONE, 0);
               @(negedge CLK);
            end
         end
         default: begin
            CAND_READY = 1'b0; RESETn = 1'b0;
            @(negedge CLK);
            check("rst_outs", {BUSY, CAND_VALID, CAND_LAST, DONE}, 0);
            check("rst_cand", CAND, 0);
            RESETn = 1'b1;
         end
      endcase
      check("count", COUNT, v.count);
   endtask

   initial begin
      vecs[0] = '{2'b00, 0, 0, 0,  0, 8'h00, 8'hEE, 64};
      vecs[1] = '{2'b01, 0, 0, 0,  0, 8'h03, 8'hEF, 64};
      vecs[2] = '{2'b10, 1, 0, 0,  0, 8'h30, 8'hFE, 64};
      vecs[3] = '{2'b11, 1, 0, 0,  0, 8'h33, 8'hFF, 64};
      vecs[4] = '{2'b00, 0, 1, 10, 0, 8'h00, 8'h00, 10};
      vecs[5] = '{2'b00, 0, 0, 0,  0, 8'h00, 8'hEE, 64};
      vecs[6] = '{2'b10, 0, 0, 0,  1, 8'h30, 8'hFE, 64};
      vecs[7] = '{2'b01, 1, 2, 30, 0, 8'h03, 8'h00, 0};

      RESETn = 1'b0; START = 1'b0; ABORT = 1'b0; CAND_READY = 1'b0; TARGET = '0;
      START5 = 1'b0; ABORT5 = 1'b0; READY5 = 1'b1; TARGET5 = '0;
      repeat (3) @(negedge CLK);
      check("reset_outs", {BUSY, CAND_VALID, CAND_LAST, DONE}, 0);
      check("reset_cand", CAND, 0);
      check("reset_count", COUNT, 0);
      RESETn = 1'b1;
      @(negedge CLK);

      // a few hand-picked sequence positions before the table runs
      check("seq_3", model(2'b00, 3), 8'h05);
      check("seq_8", model(2'b00, 8), 8'h10);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      @(negedge CLK);
      START = 1'b1; ABORT = 1'b1; TARGET = 2'b00;
      @(negedge CLK);
      START = 1'b0; ABORT = 1'b0;
      check("sa_busy", BUSY, 0);
      check("sa_valid", CAND_VALID, 0);
      @(negedge CLK);
      check("sa_busy2", BUSY, 0);

      TARGET5 = 5'h15; START5 = 1'b1;
      @(negedge CLK);
      START5 = 1'b0;
      for (int c = 0; c < 40000 && !DONE5; c++) @(negedge CLK);
      check("n5_done", DONE5, 1);
      check("n5_count", COUNT5, 32768);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
